// File: rtl/latch_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank_arbiter_if
// Description : Request/latch-bus bundle for latch_bank_arbiter. The master
//               side is the pair of requesters. The slave side is the
//               arbiter, which drives the latch data bus, the enables and
//               the write-complete acks.
// Revision    : 1.0 - initial release
// ============================================================================
interface latch_bank_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NBANK = 4
);
  localparam int AW = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic             req0;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] lat_d;
  logic [NBANK-1:0] lat_en;
  logic             ack0;
  logic             ack1;
  logic             busy;

  // Requester side
  modport master (
    output req0, addr0, data0, req1, addr1, data1,
    input  lat_d, lat_en, ack0, ack1, busy
  );

  // Arbiter side
  modport slave (
    input  req0, addr0, data0, req1, addr1, data1,
    output lat_d, lat_en, ack0, ack1, busy
  );
endinterface
`default_nettype wire

// File: rtl/latch_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : latch_bank_arbiter
// Description : Round-robin write arbiter and strobe sequencer for a bank of
//               transparent latches. Each write runs IDLE -> SETUP -> STROBE
//               -> HOLD. Data is settled for a full cycle before the one-hot
//               enable pulse and stays settled for a full cycle after it.
// Revision    : 1.0 - initial release
// ============================================================================
module latch_bank_arbiter #(
  parameter int WIDTH = 16,
  parameter int NBANK = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  latch_bank_arbiter_if.slave bus
);

  localparam int AW = (NBANK > 1) ? $clog2(NBANK) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q;
  logic [NBANK-1:0] en_q;
  logic             ack0_q;
  logic             ack1_q;
  logic             busy_q;
  logic             gnt_q;   // requester owning the write in flight
  logic             last_q;  // requester granted most recently

  logic             win_d;
  logic [NBANK-1:0] en_d;

  // Round-robin pick: a lone request wins, a tie goes to the one not granted last
  always_comb begin
    if (bus.req0 && bus.req1) begin
      win_d = ~last_q;
    end else begin
      win_d = bus.req1;
    end
  end

  // One-hot decode of the captured address; indices >= NBANK match no bit
  always_comb begin
    en_d = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (32'(addr_q) == i) begin
        en_d[i] = 1'b1;
      end
    end
  end

  // Sequencer FSM with every output taken straight from a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      en_q   <= '0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt_q   <= win_d;
            last_q  <= win_d;
            addr_q  <= win_d ? bus.addr1 : bus.addr0;
            data_q  <= win_d ? bus.data1 : bus.data0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          en_q    <= en_d;
          state_q <= STROBE;
        end
        STROBE: begin
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= HOLD;
        end
        HOLD: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.lat_d  = data_q;
  assign bus.lat_en = en_q;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_latch_bank_arbiter
// Description : Scoreboard bench for latch_bank_arbiter. It uses a 4-bank
//               instance for the arbitration and sequencing cases, and a
//               3-bank instance for the out-of-range address case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_bank_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  latch_bank_arbiter_if #(.WIDTH(16), .NBANK(4)) b ();
  latch_bank_arbiter_if #(.WIDTH(16), .NBANK(3)) b3 ();

  latch_bank_arbiter #(.WIDTH(16), .NBANK(4)) u_dut (.clk(clk), .rst(rst), .bus(b));
  latch_bank_arbiter #(.WIDTH(16), .NBANK(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    bit          who;
    logic [3:0]  en;
    logic [15:0] d;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem4 [4] = '{default: '0};
  logic [15:0] mem3 [3] = '{default: '0};
  time         t_ack0 = 0;
  time         t_ack1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_ack(input string tag, input exp_t e, input logic who,
                           input logic [3:0] sen, input logic [15:0] sd, input logic [15:0] hd);
    chk({tag, "_ack_who"}, 32'(who), 32'(e.who));
    chk({tag, "_strobe_en"}, 32'(sen), 32'(e.en));
    if (e.en != 4'd0) chk({tag, "_strobe_data"}, 32'(sd), 32'(e.d));
    chk({tag, "_hold_data"}, 32'(hd), 32'(e.d));
  endtask

  task automatic unexpected(input string tag);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_ack: got ack expected none", tag);
  endtask

  // Behavioural latch banks
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (b.lat_en[i]) mem4[i] <= b.lat_d;
    for (int i = 0; i < 3; i++) if (b3.lat_en[i]) mem3[i] <= b3.lat_d;
    if (b.ack0) t_ack0 <= $time;
    if (b.ack1) t_ack1 <= $time;
  end

  // Monitor: 4-bank instance
  logic [3:0]  seen_en4, prev_en4;
  logic [15:0] seen_d4, prev_d4;
  always @(negedge clk) begin
    if (rst) begin
      seen_en4 <= '0;
      prev_en4 <= '0;
      seen_d4  <= '0;
      prev_d4  <= b.lat_d;
    end else begin
      if (|b.lat_en) begin
        chk("strobe_onehot", 32'($onehot(b.lat_en)), 32'd1);
        chk("pre_strobe_stable", 32'(b.lat_d), 32'(prev_d4));
        seen_en4 <= b.lat_en;
        seen_d4  <= b.lat_d;
      end
      if (|prev_en4) chk("post_strobe_stable", 32'(b.lat_d), 32'(prev_d4));
      if (b.ack0 || b.ack1) begin
        chk("ack_exclusive", 32'(b.ack0 & b.ack1), 32'd0);
        if (q4.size() == 0) unexpected("dut4");
        else check_ack("dut4", q4.pop_front(), b.ack1, seen_en4, seen_d4, b.lat_d);
        seen_en4 <= '0;
      end
      prev_en4 <= b.lat_en;
      prev_d4  <= b.lat_d;
    end
  end

  // Monitor: 3-bank instance
  logic [2:0]  seen_en3;
  logic [15:0] seen_d3;
  always @(negedge clk) begin
    if (rst) begin
      seen_en3 <= '0;
      seen_d3  <= '0;
    end else begin
      if (|b3.lat_en) begin
        seen_en3 <= b3.lat_en;
        seen_d3  <= b3.lat_d;
      end
      if (b3.ack0 || b3.ack1) begin
        if (q3.size() == 0) unexpected("dut3");
        else check_ack("dut3", q3.pop_front(), b3.ack1, {1'b0, seen_en3}, seen_d3, b3.lat_d);
        seen_en3 <= '0;
      end
    end
  end

  task automatic drive0(input logic [1:0] a, input logic [15:0] d, input bit corrupt);
    bit got = 1'b0;
    b.req0 = 1'b1; b.addr0 = a; b.data0 = d;
    for (int i = 0; i < 24 && !got; i++) begin
      @(posedge clk); #1;
      if (corrupt && b.busy) begin b.data0 = 16'hFFFF; b.addr0 = ~a; end
      if (b.ack0) got = 1'b1;
    end
    b.req0 = 1'b0;
    @(posedge clk); #1;
    chk("ack0_seen", 32'(got), 32'd1);
  endtask

  task automatic drive1(input logic [1:0] a, input logic [15:0] d);
    bit got = 1'b0;
    b.req1 = 1'b1; b.addr1 = a; b.data1 = d;
    for (int i = 0; i < 24 && !got; i++) begin
      @(posedge clk); #1;
      if (b.ack1) got = 1'b1;
    end
    b.req1 = 1'b0;
    @(posedge clk); #1;
    chk("ack1_seen", 32'(got), 32'd1);
  endtask

  task automatic drive3(input logic [1:0] a, input logic [15:0] d);
    bit got = 1'b0;
    b3.req1 = 1'b1; b3.addr1 = a; b3.data1 = d;
    for (int i = 0; i < 24 && !got; i++) begin
      @(posedge clk); #1;
      if (b3.ack1) got = 1'b1;
    end
    b3.req1 = 1'b0;
    @(posedge clk); #1;
    chk("dut3_ack1_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    b.req0 = 0; b.addr0 = 0; b.data0 = 0; b.req1 = 0; b.addr1 = 0; b.data1 = 0;
    b3.req0 = 0; b3.addr0 = 0; b3.data0 = 0; b3.req1 = 0; b3.addr1 = 0; b3.data1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lat_d", 32'(b.lat_d), 32'd0);
    chk("rst_lat_en", 32'(b.lat_en), 32'd0);
    chk("rst_busy", 32'(b.busy), 32'd0);
    chk("rst_acks", 32'({b.ack0, b.ack1}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write with cycle-exact timing
    q4.push_back('{who: 1'b0, en: 4'b0100, d: 16'hA5C3});
    b.req0 = 1'b1; b.addr0 = 2'd2; b.data0 = 16'hA5C3;
    @(posedge clk); #1;
    chk("c1_lat_d", 32'(b.lat_d), 32'hA5C3);
    chk("c1_lat_en", 32'(b.lat_en), 32'd0);
    chk("c1_busy", 32'(b.busy), 32'd1);
    @(posedge clk); #1;
    chk("c2_lat_en", 32'(b.lat_en), 32'b0100);
    @(posedge clk); #1;
    chk("c3_ack0", 32'(b.ack0), 32'd1);
    chk("c3_lat_en", 32'(b.lat_en), 32'd0);
    b.req0 = 1'b0;
    @(posedge clk); #1;
    chk("c4_busy", 32'(b.busy), 32'd0);
    chk("c4_ack0", 32'(b.ack0), 32'd0);
    chk("c4_lat_d_held", 32'(b.lat_d), 32'hA5C3);
    chk("latch2", 32'(mem4[2]), 32'hA5C3);

    // Reset in the middle of a strobe drops the write with no ack
    b.req0 = 1'b1; b.addr0 = 2'd1; b.data0 = 16'hBEEF;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(posedge clk); #1;
      if (|b.lat_en) hit = 1'b1;
    end
    chk("reached_strobe", 32'(hit), 32'd1);
    b.req0 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_lat_en", 32'(b.lat_en), 32'd0);
    chk("mid_rst_lat_d", 32'(b.lat_d), 32'd0);
    chk("mid_rst_busy", 32'(b.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Tie straight after reset: requester 0 first, then requester 1
    q4.push_back('{who: 1'b0, en: 4'b0001, d: 16'h1111});
    q4.push_back('{who: 1'b1, en: 4'b1000, d: 16'h2222});
    fork
      drive0(2'd0, 16'h1111, 1'b0);
      drive1(2'd3, 16'h2222);
    join
    chk("tie_ack_gap", 32'(t_ack1 - t_ack0), 32'd40);
    chk("latch0", 32'(mem4[0]), 32'h1111);
    chk("latch3", 32'(mem4[3]), 32'h2222);

    // Fairness: continuous requests alternate 0,1,0,1,...
    for (int k = 0; k < 4; k++) begin
      q4.push_back('{who: 1'b0, en: 4'b0001 << (k % 4), d: 16'h3000 + 16'(k)});
      q4.push_back('{who: 1'b1, en: 4'b0001 << ((3 - k) % 4), d: 16'h4000 + 16'(k)});
    end
    fork
      begin
        for (int k = 0; k < 4; k++) drive0(2'(k), 16'h3000 + 16'(k), 1'b0);
      end
      begin
        for (int j = 0; j < 4; j++) drive1(2'(3 - j), 16'h4000 + 16'(j));
      end
    join

    // Data changed after capture must not reach the latch
    q4.push_back('{who: 1'b0, en: 4'b0010, d: 16'h1234});
    drive0(2'd1, 16'h1234, 1'b1);
    chk("latch1_stable", 32'(mem4[1]), 32'h1234);

    // 3-bank instance: a valid write, then an out-of-range address
    q3.push_back('{who: 1'b1, en: 4'b0010, d: 16'h5A5A});
    drive3(2'd1, 16'h5A5A);
    q3.push_back('{who: 1'b1, en: 4'b0000, d: 16'h7777});
    drive3(2'd3, 16'h7777);
    chk("dut3_latch0", 32'(mem3[0]), 32'd0);
    chk("dut3_latch1", 32'(mem3[1]), 32'h5A5A);
    chk("dut3_latch2", 32'(mem3[2]), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/latch_bank_arbiter.md
# latch_bank_arbiter

Write arbiter and strobe sequencer for a bank of 16-bit transparent latches, each built from per-bit D latches with a shared active-high enable. Two requesters share the bank. The block grants one write at a time with round-robin fairness and presents stable data before the enable rises. It generates a registered, one-hot, single-cycle enable pulse and keeps the data stable after the enable falls, so no latch ever sees data change while it is transparent.

## Interface
Parameters:
- WIDTH, 16: data width of each latch.
- NBANK, 4: number of latches in the bank; AW = clog2(NBANK).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 write request; held high until ack0.
- addr0  input  AW  requester 0 target latch index.
- data0  input  WIDTH  requester 0 write data.
- req1  input  1  requester 1 write request; held high until ack1.
- addr1  input  AW  requester 1 target latch index.
- data1  input  WIDTH  requester 1 write data.
- lat_d  output  WIDTH  data bus driven to every latch `in`.
- lat_en  output  NBANK  one-hot latch enables, registered.
- ack0  output  1  one-cycle pulse: requester 0 write complete.
- ack1  output  1  one-cycle pulse: requester 1 write complete.
- busy  output  1  high whenever the FSM is not IDLE.

## Operation
FSM states: IDLE, SETUP, STROBE, HOLD.

- IDLE: the FSM samples req0/req1.
  - If any request is present, the arbiter picks a winner and the FSM goes to SETUP.
  - On the same edge it captures the winner's addr and data into internal registers and records the winner in gnt.
- SETUP: lat_d drives the captured data; lat_en stays 0. Next state is STROBE.
- STROBE: lat_en[captured addr] = 1 and all other bits are 0; lat_d is unchanged. Next state is HOLD.
- HOLD: lat_en is all 0; lat_d is unchanged. ack of the granted requester is 1. Next state is IDLE.

Arbitration:
- A single request wins.
- When both requests are present, the requester not granted last time wins.
- The last-grant pointer resets to 1, so requester 0 wins the first tie.
- The pointer updates only on a grant.

Request/ack rules:
- Data, address and requests are ignored outside IDLE. Changes to addr or data after capture have no effect.
- A requester deasserts req in the cycle after its ack. A req still high in IDLE is treated as a new request.

Outputs:
- lat_en, ack0, ack1 and busy are driven from registered state only, so they are glitch-free.
- lat_d holds its last captured value in IDLE; it does not return to 0.
- An out-of-range address (addr ≥ NBANK) produces lat_en = 0 in STROBE. The ack is still issued.

Reset (asynchronous, effective immediately, including mid-operation):
- FSM returns to IDLE.
- lat_d = 0, lat_en = 0, ack0 = ack1 = 0, busy = 0, last-grant = 1.
- A write interrupted by reset is dropped with no ack. If reset lands in STROBE, the target latch may retain partially updated content; this is acceptable.

## Timing
- Request seen at edge N (FSM in IDLE):
  - SETUP during N+1 to N+2, lat_d valid.
  - STROBE during N+2 to N+3, lat_en high for exactly 1 cycle.
  - HOLD during N+3 to N+4, ack high.
  - IDLE at N+4.
- Write latency is 4 cycles from grant to IDLE; ack arrives 3 cycles after grant.
- Maximum throughput is one write per 4 cycles. A pending loser is granted at the IDLE edge N+4.
- lat_d is stable for 1 full cycle before lat_en rises and 1 full cycle after it falls.
- busy is high from N+1 through N+4 (exclusive of N+4).

## Test plan
- Reset: assert rst mid-STROBE → lat_en = 0, lat_d = 0, busy = 0 immediately. No ack. A later req0 wins.
- Single write: req0 = 1, addr0 = 2, data0 = 0xA5C3.
  - lat_d = 0xA5C3 from cycle 1.
  - lat_en = 4'b0100 in cycle 2 only.
  - ack0 in cycle 3.
  - The latch model at index 2 outputs 0xA5C3.
- Tie after reset: req0 and req1 both high, addr0 = 0 / data0 = 0x1111, addr1 = 3 / data1 = 0x2222.
  - Grant goes to 0: ack0, then lat_en = 4'b0001 with 0x1111.
  - Then requester 1 is granted: lat_en = 4'b1000 with 0x2222, ack1 four cycles after ack0.
- Fairness: both requesters re-request continuously for 8 writes → grants alternate 0,1,0,1,…; no requester is granted twice in a row.
- Data stability: data0 changes to 0xFFFF during SETUP/STROBE → latch captures the original value; lat_d never changes while any lat_en bit is high.
- Out-of-range address with NBANK = 3: addr1 = 3 → lat_en = 0 throughout, ack1 still pulses, latch contents unchanged.
